// File: rtl/uart_pkg.sv
// uart_pkg: shared type and default constants for the UART transmitter slice.
//   uart_tx_state_t    : transmitter FSM state encoding
//   UART_CLKS_PER_BIT  : default clock cycles per serial bit
//   UART_DATA_BITS     : default payload bits per frame
//   UART_STOP_BITS     : default stop bits per frame
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_DONE  = 3'd4
   } uart_tx_state_t;

   localparam int UART_CLKS_PER_BIT = 868;
   localparam int UART_DATA_BITS    = 8;
   localparam int UART_STOP_BITS    = 1;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART transmitter.
//   clk      : system clock
//   i_reset  : asynchronous active-high reset
//   clear    : holds the counter at 0 (restarts the bit period)
//   bit_done : high on the final cycle (count CLKS_PER_BIT-1) of each bit period
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic i_reset,
   input  logic clear,
   output logic bit_done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_r;
   logic             last_s;

   // Terminal-count decode; suppressed while the timer is held in clear.
   always_comb begin
      last_s   = (cnt_r == CNT_LAST);
      bit_done = 1'b0;
      if (!clear) begin
         bit_done = last_s;
      end else begin
         bit_done = 1'b0;
      end
   end

   // Free-running 0..CLKS_PER_BIT-1 counter that wraps at the end of every bit.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (last_s) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

endmodule : uart_baud_gen

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1-style UART transmitter (configurable data/stop bits, no parity).
//   clk                  : system clock
//   i_reset              : asynchronous active-high reset
//   i_start_transmission : level-sensitive send request, honoured only in IDLE
//   i_data               : payload, captured on the accepting edge
//   o_tx                 : serial line (idle high), registered
//   o_busy               : high while start/data/stop bits are on the line
//   o_done               : one-cycle pulse after the last stop bit
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DATA_BITS    = UART_DATA_BITS,
   parameter int STOP_BITS    = UART_STOP_BITS
) (
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic                 i_start_transmission,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int DATA_IDX_W = $clog2(DATA_BITS);
   // A single stop bit would give a zero-width index; keep at least one bit.
   localparam int STOP_IDX_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
   localparam logic [DATA_IDX_W-1:0] DATA_LAST = DATA_IDX_W'(DATA_BITS - 1);
   localparam logic [STOP_IDX_W-1:0] STOP_LAST = STOP_IDX_W'(STOP_BITS - 1);

   uart_tx_state_t          state_r, next_state_s;
   logic [DATA_BITS-1:0]    shift_r, shift_next_s;
   logic [DATA_IDX_W-1:0]   data_idx_r, data_idx_next_s;
   logic [STOP_IDX_W-1:0]   stop_idx_r, stop_idx_next_s;
   logic                    tx_r, busy_r, done_r;
   logic                    tx_next_s, busy_next_s, done_next_s;
   logic                    baud_clear_s, bit_done_s;

   // The bit timer runs only while a bit is on the line, so it starts from 0 on acceptance.
   always_comb begin
      baud_clear_s = 1'b1;
      case (state_r)
         ST_START, ST_DATA, ST_STOP: baud_clear_s = 1'b0;
         default:                    baud_clear_s = 1'b1;
      endcase
   end

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_gen (
      .clk      (clk),
      .i_reset  (i_reset),
      .clear    (baud_clear_s),
      .bit_done (bit_done_s)
   );

   // Next-state, shift register and bit-index update.
   always_comb begin
      next_state_s    = state_r;
      shift_next_s    = shift_r;
      data_idx_next_s = data_idx_r;
      stop_idx_next_s = stop_idx_r;
      case (state_r)
         ST_IDLE: begin
            if (i_start_transmission) begin
               next_state_s    = ST_START;
               shift_next_s    = i_data;
               data_idx_next_s = '0;
               stop_idx_next_s = '0;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (bit_done_s) begin
               next_state_s = ST_DATA;
            end else begin
               next_state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_done_s) begin
               if (data_idx_r == DATA_LAST) begin
                  next_state_s    = ST_STOP;
                  data_idx_next_s = '0;
               end else begin
                  data_idx_next_s = data_idx_r + DATA_IDX_W'(1);
                  shift_next_s    = {1'b0, shift_r[DATA_BITS-1:1]};
               end
            end else begin
               next_state_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (bit_done_s) begin
               if (stop_idx_r == STOP_LAST) begin
                  next_state_s    = ST_DONE;
                  stop_idx_next_s = '0;
               end else begin
                  stop_idx_next_s = stop_idx_r + STOP_IDX_W'(1);
               end
            end else begin
               next_state_s = ST_STOP;
            end
         end
         ST_DONE: next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered line changes on the
   // same edge as the state (o_tx goes low right after the accepting edge).
   always_comb begin
      tx_next_s   = 1'b1;
      busy_next_s = 1'b0;
      done_next_s = 1'b0;
      case (next_state_s)
         ST_START: begin
            tx_next_s   = 1'b0;
            busy_next_s = 1'b1;
         end
         ST_DATA: begin
            tx_next_s   = shift_next_s[0];
            busy_next_s = 1'b1;
         end
         ST_STOP: begin
            tx_next_s   = 1'b1;
            busy_next_s = 1'b1;
         end
         ST_DONE: begin
            tx_next_s   = 1'b1;
            done_next_s = 1'b1;
         end
         default: begin
            tx_next_s   = 1'b1;
            busy_next_s = 1'b0;
            done_next_s = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset aborts any frame immediately.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state_r    <= ST_IDLE;
         shift_r    <= '0;
         data_idx_r <= '0;
         stop_idx_r <= '0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         shift_r    <= shift_next_s;
         data_idx_r <= data_idx_next_s;
         stop_idx_r <= stop_idx_next_s;
         tx_r       <= tx_next_s;
         busy_r     <= busy_next_s;
         done_r     <= done_next_s;
      end
   end

   assign o_tx   = tx_r;
   assign o_busy = busy_r;
   assign o_done = done_r;

endmodule : uart_transmitter

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed + randomized self-checking bench for uart_transmitter.
// Expected line levels come from the frame definition: cycle i of a frame carries
// bit i/CLKS_PER_BIT, where bit 0 is the start bit, bits 1..DATA_BITS are the
// payload LSB first, and everything after is stop level.
module tb_uart_transmitter;

   localparam int CPB        = 4;
   localparam int NB         = 8;
   localparam int NS         = 1;
   localparam int FRAME      = (1 + NB + NS) * CPB;
   localparam int MODE_PULSE = 0;
   localparam int MODE_HOLD  = 1;
   localparam int MODE_MID   = 2;
   localparam int B_CPB      = 868;
   localparam int B_FRAME    = 11 * B_CPB;

   logic       clk = 1'b0;
   logic       i_reset;
   logic       i_start_transmission;
   logic [7:0] i_data;
   logic       o_tx, o_busy, o_done;
   logic       b_start;
   logic [7:0] b_data;
   logic       b_tx, b_busy, b_done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB), .STOP_BITS(NS)) dut (
      .clk                  (clk),
      .i_reset              (i_reset),
      .i_start_transmission (i_start_transmission),
      .i_data               (i_data),
      .o_tx                 (o_tx),
      .o_busy               (o_busy),
      .o_done               (o_done)
   );

   uart_transmitter #(.CLKS_PER_BIT(B_CPB), .DATA_BITS(8), .STOP_BITS(2)) dut_b (
      .clk                  (clk),
      .i_reset              (i_reset),
      .i_start_transmission (b_start),
      .i_data               (b_data),
      .o_tx                 (b_tx),
      .o_busy               (b_busy),
      .o_done               (b_done)
   );

   function automatic logic exp_tx(input logic [7:0] d, input int i, input int cpb, input int nd);
      int b;
      b = i / cpb;
      if (b == 0) return 1'b0;
      else if (b <= nd) return d[b-1];
      else return 1'b1;
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_n(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx"},   o_tx,   1'b1);
      check({tag, "_busy"}, o_busy, 1'b0);
      check({tag, "_done"}, o_done, 1'b0);
   endtask

   // Called right after the negedge where the request was raised; ends on the
   // negedge of the IDLE cycle that follows DONE.
   task automatic expect_frame(input logic [7:0] d, input int mode, input string tag);
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         check({tag, "_tx"},   o_tx,   exp_tx(d, i, CPB, NB));
         check({tag, "_busy"}, o_busy, 1'b1);
         check({tag, "_done"}, o_done, 1'b0);
         if (mode == MODE_PULSE && i == 0) begin
            i_start_transmission = 1'b0;
         end else if (mode == MODE_MID && i == FRAME / 2) begin
            i_data               = 8'h00;
            i_start_transmission = 1'b1;
         end else if (mode == MODE_MID && i == FRAME / 2 + 1) begin
            i_start_transmission = 1'b0;
         end
      end
      @(negedge clk);
      check({tag, "_done_pulse"}, o_done, 1'b1);
      check({tag, "_done_tx"},    o_tx,   1'b1);
      check({tag, "_done_busy"},  o_busy, 1'b0);
      @(negedge clk);
      check_idle({tag, "_gap"});
   endtask

   initial begin
      logic [7:0] d;
      int         gap;
      int         busy_cnt, mism, run, done_cnt, idx;

      i_reset              = 1'b1;
      i_start_transmission = 1'b0;
      i_data               = 8'h00;
      b_start              = 1'b0;
      b_data               = 8'h00;

      // Reset held 10 cycles, then idle with no request.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_idle("reset");
      end
      i_reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_idle("post_reset_idle");
      end

      // 8'hF0 with a one-cycle start pulse.
      i_data = 8'hF0;
      i_start_transmission = 1'b1;
      expect_frame(8'hF0, MODE_PULSE, "f0");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_idle("f0_after");
      end

      // 8'hA5 with start held: back-to-back frames, 2-cycle high gap.
      i_data = 8'hA5;
      i_start_transmission = 1'b1;
      expect_frame(8'hA5, MODE_HOLD,  "a5_1");
      expect_frame(8'hA5, MODE_HOLD,  "a5_2");
      expect_frame(8'hA5, MODE_PULSE, "a5_3");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_idle("a5_after");
      end

      // Data changed and start re-pulsed mid-frame: no effect, no extra frame.
      i_data = 8'h96;
      i_start_transmission = 1'b1;
      expect_frame(8'h96, MODE_MID, "mid");
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         check_idle("mid_no_extra");
      end

      // Randomized payloads and inter-frame gaps.
      for (int k = 0; k < 4; k++) begin
         d   = 8'($urandom_range(0, 255));
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_idle("rand_gap");
         end
         i_data = d;
         i_start_transmission = 1'b1;
         expect_frame(d, MODE_PULSE, "rand");
      end

      // Reset during the 3rd data bit (frame cycles 12..15); reset acts without a clock edge.
      i_data = 8'h3C;
      i_start_transmission = 1'b1;
      @(negedge clk);
      i_start_transmission = 1'b0;
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
      end
      check("mid_reset_pre_tx", o_tx, exp_tx(8'h3C, 13, CPB, NB));
      i_reset = 1'b1;
      #1;
      check("async_reset_tx",   o_tx,   1'b1);
      check("async_reset_busy", o_busy, 1'b0);
      check("async_reset_done", o_done, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle("in_reset");
      end
      i_reset = 1'b0;
      d = 8'($urandom_range(0, 255));
      i_data = d;
      i_start_transmission = 1'b1;
      expect_frame(d, MODE_PULSE, "after_abort");

      // Two stop bits, 868 clocks per bit, payload 8'h55.
      b_data  = 8'h55;
      b_start = 1'b1;
      busy_cnt = 0;
      mism     = 0;
      run      = 0;
      done_cnt = 0;
      idx      = 0;
      for (int n = 0; n < B_FRAME + 6; n++) begin
         @(negedge clk);
         if (n == 0) b_start = 1'b0;
         if (b_done) done_cnt++;
         if (b_busy) begin
            busy_cnt++;
            if (b_tx !== exp_tx(8'h55, idx, B_CPB, 8)) mism++;
            if (b_tx === 1'b1) run++;
            else run = 0;
            idx++;
         end
      end
      check_n("b_frame_len",  busy_cnt, B_FRAME);
      check_n("b_bit_errors", mism,     0);
      check_n("b_stop_len",   run,      2 * B_CPB);
      check_n("b_done_count", done_cnt, 1);
      check("b_idle_tx", b_tx, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_uart_transmitter
